mac_seq_ctrl: RTL and testbench

- Sequencing controller for the multiply-accumulate datapath of the DSP unit.
- The datapath is a chain of enable-gated, synchronously-reset pipeline registers, an accumulator and a result register.
- This block accepts a frame of operand samples over a valid/ready handshake and drives per-stage clock enables, accumulator clear/enable and result capture.
- It presents the finished frame result to a downstream consumer through a valid/ready handshake.

---
 rtl/mac_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for the DSP multiply-accumulate datapath.
// Accepts a frame of operand samples, walks a token through the pipeline
// to gate each register stage, and hands the finished result downstream.
module mac_seq_ctrl #(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  a_rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  frame_len,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PIPE_DEPTH-1:0] ce_stage,
    output logic                  acc_ce,
    output logic                  acc_clr,
    output logic                  res_ce,
    output logic                  dp_s_rst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RESULT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PIPE_DEPTH-1:0] r_tok;
    logic [PIPE_DEPTH-1:0] r_fst;
    logic [PIPE_DEPTH-1:0] w_tok_nxt;
    logic [PIPE_DEPTH-1:0] w_fst_nxt;
    logic [CNT_WIDTH-1:0]  r_len;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;
    logic [CNT_WIDTH-1:0]  r_ret_cnt;
    logic [CNT_WIDTH-1:0]  w_frame_inc;
    logic [CNT_WIDTH-1:0]  w_ret_inc;
    logic                  r_res_ce;
    logic                  r_busy;
    logic                  r_dp_s_rst;
    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_abort_ok;
    logic                  w_last_acc;
    logic                  w_last_ret;

    assign in_ready    = (r_state == S_LOAD);
    assign out_valid   = (r_state == S_DONE);
    assign w_accept    = in_valid & in_ready;
    assign w_start_ok  = (r_state == S_IDLE) & start & (frame_len != '0);
    assign w_abort_ok  = abort & (r_state != S_IDLE);
    assign w_frame_inc = r_frame_cnt + CNT_WIDTH'(1);
    assign w_ret_inc   = r_ret_cnt + CNT_WIDTH'(1);
    assign w_last_acc  = w_accept & (w_frame_inc == r_len);
    assign w_last_ret  = r_tok[PIPE_DEPTH-1] & (w_ret_inc == r_len);

    // Stage k is enabled by the token that entered k cycles ago; the first-sample
    // marker travels alongside so acc_clr comes straight off a flop.
    assign w_tok_nxt = (r_tok << 1) | PIPE_DEPTH'(w_accept);
    assign w_fst_nxt = (r_fst << 1) | PIPE_DEPTH'(w_accept & (r_frame_cnt == '0));

    assign ce_stage  = w_tok_nxt;
    assign acc_ce    = r_tok[PIPE_DEPTH-1];
    assign acc_clr   = r_fst[PIPE_DEPTH-1];
    assign res_ce    = r_res_ce;
    assign dp_s_rst  = r_dp_s_rst;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

    // State register.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort_ok) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_start_ok) w_state_nxt = S_LOAD;
                S_LOAD: begin
                    if (w_last_ret)      w_state_nxt = S_RESULT;
                    else if (w_last_acc) w_state_nxt = S_DRAIN;
                end
                S_DRAIN:  if (w_last_ret) w_state_nxt = S_RESULT;
                S_RESULT: w_state_nxt = S_DONE;
                S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Token pipe and first-sample marker pipe.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_tok <= '0;
            r_fst <= '0;
        end else if (w_abort_ok) begin
            r_tok <= '0;
            r_fst <= '0;
        end else begin
            r_tok <= w_tok_nxt;
            r_fst <= w_fst_nxt;
        end
    end

    // Frame length latch plus accepted and retired sample counters.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_len       <= '0;
            r_frame_cnt <= '0;
            r_ret_cnt   <= '0;
        end else if (w_abort_ok) begin
            r_frame_cnt <= '0;
            r_ret_cnt   <= '0;
        end else if (w_start_ok) begin
            r_len       <= frame_len;
            r_frame_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if (w_accept) r_frame_cnt <= w_frame_inc;
            if (acc_ce)   r_ret_cnt   <= w_ret_inc;
        end
    end

    // Registered status strobes, derived from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_res_ce   <= 1'b0;
            r_busy     <= 1'b0;
            r_dp_s_rst <= 1'b0;
        end else begin
            r_res_ce   <= (w_state_nxt == S_RESULT);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_dp_s_rst <= w_abort_ok;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: stimulus pushes expected events derived
// from the frame rules, a negedge monitor pops and compares them.
module tb_mac_seq_ctrl;

    localparam int PD = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          a_rst_n;
    logic          start;
    logic [CW-1:0] frame_len;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [PD-1:0] ce_stage;
    logic          acc_ce;
    logic          acc_clr;
    logic          res_ce;
    logic          dp_s_rst;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    typedef struct { int cyc; int clr; } acc_t;
    typedef struct { int first; int last; int cnt; } ov_t;

    acc_t q_acc[$];
    int   q_res[$];
    int   q_dp[$];
    ov_t  q_ov[$];
    int   exp_ce[int];

    acc_t m_a;
    int   m_exp;

    mac_seq_ctrl #(.PIPE_DEPTH(PD), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .a_rst_n   (a_rst_n),
        .start     (start),
        .frame_len (frame_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ce_stage  (ce_stage),
        .acc_ce    (acc_ce),
        .acc_clr   (acc_clr),
        .res_ce    (res_ce),
        .dp_s_rst  (dp_s_rst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic fail_evt(input string name, input int act, input int exp);
        n_total++;
        $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_busy"},      int'(busy),      0);
        chk_eq({tag, "_in_ready"},  int'(in_ready),  0);
        chk_eq({tag, "_ce_stage"},  int'(ce_stage),  0);
        chk_eq({tag, "_acc_ce"},    int'(acc_ce),    0);
        chk_eq({tag, "_acc_clr"},   int'(acc_clr),   0);
        chk_eq({tag, "_res_ce"},    int'(res_ce),    0);
        chk_eq({tag, "_dp_s_rst"},  int'(dp_s_rst),  0);
        chk_eq({tag, "_out_valid"}, int'(out_valid), 0);
        chk_eq({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    // Sample accepted at cycle c: stage k fires at c+k, accumulator at c+PD.
    task automatic push_accept(input int c, input int first);
        acc_t a;
        for (int s = 0; s < PD; s++) begin
            if (exp_ce.exists(c + s)) exp_ce[c + s] = exp_ce[c + s] | (1 << s);
            else exp_ce[c + s] = (1 << s);
        end
        a.cyc = c + PD;
        a.clr = first;
        q_acc.push_back(a);
    endtask

    // Abort seen at cycle a_cyc: pipe empties from the next cycle on.
    task automatic do_abort_flush(input int a_cyc);
        while (q_acc.size() > 0 && q_acc[$].cyc > a_cyc) void'(q_acc.pop_back());
        for (int c = a_cyc + 1; c <= a_cyc + PD; c++)
            if (exp_ce.exists(c)) exp_ce.delete(c);
        q_dp.push_back(a_cyc + 1);
    endtask

    task automatic do_abort(input string tag);
        in_valid  = 1'b0;
        abort     = 1'b1;
        start     = 1'b1;
        frame_len = 8'd5;
        out_ready = 1'b1;
        do_abort_flush(cyc);
        tick();
        abort     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        chk_eq({tag, "_busy"},      int'(busy),      0);
        chk_eq({tag, "_in_ready"},  int'(in_ready),  0);
        chk_eq({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    // kind 0: normal; 1: abort once k samples accepted (k>=len: in DRAIN);
    // 2: async reset in DRAIN. vpct<0 selects alternating valid from the first LOAD cycle.
    task automatic run_frame(input int len, input int vpct, input int kind,
                             input int k, input int hold);
        int acc;
        int c0;
        int t_last;
        int d;
        int h;
        bit v;
        ov_t o;
        acc    = 0;
        t_last = 0;
        chk_eq("busy_idle", int'(busy), 0);
        start     = 1'b1;
        frame_len = CW'(len);
        c0        = cyc;
        tick();
        start     = 1'b0;
        frame_len = CW'($urandom);
        chk_eq("busy_load",      int'(busy),      1);
        chk_eq("in_ready_load",  int'(in_ready),  1);
        chk_eq("frame_cnt_init", int'(frame_cnt), 0);
        while (acc < len) begin
            if (kind == 1 && acc == k) begin
                do_abort("abort_load");
                return;
            end
            if (vpct < 0) v = (((cyc - c0 - 1) % 2) == 0);
            else          v = (int'($urandom_range(99)) < vpct);
            in_valid = v;
            if (v) begin
                push_accept(cyc, (acc == 0) ? 1 : 0);
                acc++;
                t_last = cyc;
            end
            tick();
        end
        in_valid = 1'($urandom_range(1));
        if (kind == 1) begin
            chk_eq("in_ready_drain", int'(in_ready), 0);
            do_abort("abort_drain");
            return;
        end
        if (kind == 2) begin
            in_valid = 1'b0;
            chk_eq("busy_drain", int'(busy), 1);
            #2;
            a_rst_n = 1'b0;
            #1;
            check_all_zero("async_rst");
            q_acc.delete();
            q_res.delete();
            q_dp.delete();
            q_ov.delete();
            exp_ce.delete();
            #2;
            a_rst_n = 1'b1;
            tick();
            return;
        end
        d = t_last + PD + 2;
        h = d + hold;
        q_res.push_back(t_last + PD + 1);
        o.first = d;
        o.last  = h;
        o.cnt   = len;
        q_ov.push_back(o);
        while (cyc < h) begin
            out_ready = (cyc < d) ? 1'($urandom_range(1)) : 1'b0;
            start     = (cyc == d + 2) || ($urandom_range(3) == 0);
            frame_len = CW'($urandom_range(1, 255));
            in_valid  = 1'($urandom_range(1));
            tick();
        end
        out_ready = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk_eq("busy_after_done",     int'(busy),      0);
        chk_eq("out_valid_after_done", int'(out_valid), 0);
    endtask

    // Monitor: pop and compare whenever the DUT presents an event.
    always @(negedge clk) begin
        if (a_rst_n && mon_en) begin
            if (q_acc.size() > 0 && q_acc[0].cyc < cyc) begin
                fail_evt("acc_ce_missing", cyc, q_acc[0].cyc);
                void'(q_acc.pop_front());
            end
            if (acc_ce) begin
                if (q_acc.size() == 0) fail_evt("acc_ce_unexpected", 1, 0);
                else begin
                    m_a = q_acc.pop_front();
                    chk_eq("acc_ce_cycle", cyc, m_a.cyc);
                    chk_eq("acc_clr", int'(acc_clr), m_a.clr);
                end
            end else if (acc_clr) fail_evt("acc_clr_without_acc_ce", 1, 0);

            if (q_res.size() > 0 && q_res[0] < cyc) begin
                fail_evt("res_ce_missing", cyc, q_res[0]);
                void'(q_res.pop_front());
            end
            if (res_ce) begin
                if (q_res.size() == 0) fail_evt("res_ce_unexpected", 1, 0);
                else chk_eq("res_ce_cycle", cyc, q_res.pop_front());
            end

            if (q_dp.size() > 0 && q_dp[0] < cyc) begin
                fail_evt("dp_s_rst_missing", cyc, q_dp[0]);
                void'(q_dp.pop_front());
            end
            if (dp_s_rst) begin
                if (q_dp.size() == 0) fail_evt("dp_s_rst_unexpected", 1, 0);
                else chk_eq("dp_s_rst_cycle", cyc, q_dp.pop_front());
            end

            if (q_ov.size() > 0 && !out_valid && cyc >= q_ov[0].first) begin
                fail_evt("out_valid_missing", 0, 1);
                void'(q_ov.pop_front());
            end
            if (out_valid) begin
                if (q_ov.size() == 0 || cyc < q_ov[0].first) fail_evt("out_valid_unexpected", 1, 0);
                else begin
                    chk_eq("frame_cnt_done", int'(frame_cnt), q_ov[0].cnt);
                    if (cyc >= q_ov[0].last) void'(q_ov.pop_front());
                end
            end

            m_exp = exp_ce.exists(cyc) ? exp_ce[cyc] : 0;
            if (m_exp != 0 || ce_stage != '0) chk_eq("ce_stage", int'(ce_stage), m_exp);
            if (exp_ce.exists(cyc)) exp_ce.delete(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: cycle %0d got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int kind;
        a_rst_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        frame_len = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        a_rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        run_frame(4, 100, 0, 0, 0);
        run_frame(3, -1, 0, 0, 0);
        run_frame(1, 100, 0, 0, 0);
        run_frame(2, 100, 0, 0, 10);
        run_frame(5, 100, 1, 2, 0);

        start     = 1'b1;
        frame_len = '0;
        tick();
        start     = 1'b0;
        chk_eq("zero_len_busy",     int'(busy),     0);
        chk_eq("zero_len_in_ready", int'(in_ready), 0);
        tick();

        run_frame(3, 100, 2, 0, 0);
        run_frame(2, 100, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            len  = int'($urandom_range(1, 12));
            kind = ($urandom_range(9) == 0) ? 1 : 0;
            run_frame(len, int'($urandom_range(20, 100)), kind,
                      int'($urandom_range(0, len)), int'($urandom_range(0, 4)));
        end

        run_frame(255, 100, 0, 0, 1);

        repeat (5) tick();
        chk_eq("q_acc_drained", q_acc.size(), 0);
        chk_eq("q_res_drained", q_res.size(), 0);
        chk_eq("q_dp_drained",  q_dp.size(),  0);
        chk_eq("q_ov_drained",  q_ov.size(),  0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
